// File: rtl/calc_dispatch.sv
`default_nettype none
// ==========================================================================
// calc_dispatch : reads jobs from host RX FIFO, feeds one calc unit, returns results
// Revision 1.0
// ==========================================================================
module calc_dispatch #(
  parameter int RAH_PACKET_WIDTH = 48,
  parameter int NUM_UNITS        = 4,
  parameter int BUF_DEPTH        = 32,
  parameter int TIMEOUT          = 65535
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [RAH_PACKET_WIDTH-1:0]           rx_data,
  input  logic                                  rx_empty,
  output logic                                  rx_rden,
  output logic [RAH_PACKET_WIDTH-1:0]           tx_data,
  output logic                                  tx_wren,
  input  logic                                  tx_full,
  output logic [RAH_PACKET_WIDTH-1:0]           u_a,
  output logic [NUM_UNITS-1:0]                  u_empty,
  input  logic [NUM_UNITS-1:0]                  u_rden,
  input  logic [NUM_UNITS*RAH_PACKET_WIDTH-1:0] u_c,
  input  logic [NUM_UNITS-1:0]                  u_wren,
  output logic                                  busy,
  output logic                                  err_ovf,
  output logic                                  err_tmo
);

  localparam int c_w     = RAH_PACKET_WIDTH;
  localparam int c_cnt_w = $clog2(BUF_DEPTH + 1);
  localparam int c_adr_w = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int c_tmo_w = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(BUF_DEPTH);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);
  localparam logic [2:0]         c_units    = 3'(NUM_UNITS);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR_RD  = 3'd1,
    ST_OPND_RD = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_COLLECT = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_ERR     = 3'd6
  } state_t;

  state_t               r_state;
  logic [1:0]           r_phase;
  logic                 r_rx_rden;
  logic [7:0]           r_tag;
  logic [1:0]           r_sel;
  logic [c_w-1:0]       r_opnd;
  logic [NUM_UNITS-1:0] r_u_empty;
  logic [c_cnt_w-1:0]   r_count;
  logic [c_cnt_w-1:0]   r_rd_idx;
  logic [c_tmo_w-1:0]   r_tmo;
  logic                 r_wren_prev;
  logic [c_w-1:0]       r_tx_data;
  logic                 r_tx_pend;
  logic                 r_err_ovf;
  logic                 r_err_tmo;
  logic [c_w-1:0]       r_mem [BUF_DEPTH];

  logic [NUM_UNITS-1:0] w_sel_hot;
  logic                 w_sel_ok;
  logic                 w_rden_sel;
  logic                 w_wren_sel;
  logic [c_w-1:0]       w_uc;
  logic [5:0]           w_cnt6;
  logic [c_w-1:0]       w_hdr_word;
  logic [c_w-1:0]       w_err_word;
  logic [c_w-1:0]       w_rd_word;
  logic                 w_tx_accept;
  logic                 w_mem_we;

  for (genvar k = 0; k < NUM_UNITS; k++) begin : g_sel_hot
    assign w_sel_hot[k] = (r_sel == 2'(k));
  end

  always_comb begin
    w_uc = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (w_sel_hot[k]) w_uc = u_c[k*c_w +: c_w];
    end
  end

  assign w_sel_ok    = ({1'b0, r_sel} < c_units);
  assign w_rden_sel  = |(u_rden & w_sel_hot);
  assign w_wren_sel  = |(u_wren & w_sel_hot);
  assign w_cnt6      = 6'(r_count);
  // Result header: tag on top, count and unit select in the low byte
  assign w_hdr_word  = {r_tag, {(c_w-16){1'b0}}, w_cnt6, r_sel};
  assign w_err_word  = {r_tag, {(c_w-8){1'b1}}};
  assign w_rd_word   = r_mem[r_rd_idx[c_adr_w-1:0]];
  // tx_wren is gated combinationally so it can never coincide with tx_full
  assign w_tx_accept = r_tx_pend & ~tx_full;
  assign w_mem_we    = (r_state == ST_COLLECT) && w_wren_sel && (r_count < c_depth);

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_count[c_adr_w-1:0]] <= w_uc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_phase     <= '0;
      r_rx_rden   <= 1'b0;
      r_tag       <= '0;
      r_sel       <= '0;
      r_opnd      <= '0;
      r_u_empty   <= '1;
      r_count     <= '0;
      r_rd_idx    <= '0;
      r_tmo       <= '0;
      r_wren_prev <= 1'b0;
      r_tx_data   <= '0;
      r_tx_pend   <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_err_tmo   <= 1'b0;
    end else begin
      r_rx_rden <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!rx_empty) begin
            r_state   <= ST_HDR_RD;
            r_rx_rden <= 1'b1;
            r_phase   <= 2'd1;
            r_count   <= '0;
          end
        end
        // Phase 1 is the strobe cycle; data is valid in phase 3
        ST_HDR_RD: begin
          if (r_phase == 2'd3) begin
            r_tag   <= rx_data[c_w-1 -: 8];
            r_sel   <= rx_data[1:0];
            r_phase <= 2'd0;
            r_state <= ST_OPND_RD;
          end else begin
            r_phase <= r_phase + 2'd1;
          end
        end
        ST_OPND_RD: begin
          if (r_phase == 2'd0) begin
            if (!rx_empty) begin
              r_rx_rden <= 1'b1;
              r_phase   <= 2'd1;
            end
          end else if (r_phase == 2'd3) begin
            r_opnd  <= rx_data;
            r_phase <= 2'd0;
            if (w_sel_ok) begin
              r_u_empty <= ~w_sel_hot;
              r_state   <= ST_ISSUE;
            end else begin
              r_tx_data <= w_err_word;
              r_tx_pend <= 1'b1;
              r_state   <= ST_ERR;
            end
          end else begin
            r_phase <= r_phase + 2'd1;
          end
        end
        ST_ISSUE: begin
          if (w_rden_sel) begin
            r_u_empty   <= '1;
            r_tmo       <= '0;
            r_wren_prev <= 1'b0;
            r_state     <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          r_wren_prev <= w_wren_sel;
          if (w_wren_sel) begin
            r_tmo <= '0;
            if (r_count < c_depth) r_count <= r_count + c_cnt_w'(1);
            else                   r_err_ovf <= 1'b1;
          end else if (r_wren_prev) begin
            r_tx_data <= w_hdr_word;
            r_tx_pend <= 1'b1;
            r_rd_idx  <= '0;
            r_state   <= ST_DRAIN;
          end else if (r_tmo == c_tmo_last) begin
            r_err_tmo <= 1'b1;
            r_tx_data <= w_err_word;
            r_tx_pend <= 1'b1;
            r_state   <= ST_ERR;
          end else begin
            r_tmo <= r_tmo + c_tmo_w'(1);
          end
        end
        ST_DRAIN: begin
          if (w_tx_accept) begin
            if (r_rd_idx < r_count) begin
              r_tx_data <= w_rd_word;
              r_rd_idx  <= r_rd_idx + c_cnt_w'(1);
            end else begin
              r_tx_pend <= 1'b0;
              r_count   <= '0;
              r_state   <= ST_IDLE;
            end
          end
        end
        ST_ERR: begin
          if (w_tx_accept) begin
            r_tx_pend <= 1'b0;
            r_count   <= '0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rx_rden = r_rx_rden;
  assign tx_data = r_tx_data;
  assign tx_wren = w_tx_accept;
  assign u_a     = r_opnd;
  assign u_empty = r_u_empty;
  assign busy    = (r_state != ST_IDLE);
  assign err_ovf = r_err_ovf;
  assign err_tmo = r_err_tmo;

endmodule
`default_nettype wire
